fifo_burst_reader: RTL and testbench

FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

---
 rtl/fifo_burst_reader_pkg.sv | 15 +
 rtl/fifo_burst_reader_skid_buf.sv | 88 ++++++++
 rtl/fifo_burst_reader.sv | 107 ++++++++++
 tb/tb_fifo_burst_reader.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_burst_reader_pkg.sv
// Shared definitions for the FIFO read-side burst reader.
// Contents:
//   state_e     : burst controller states (IDLE=0, RUN=1, DONE=2)
//   SKID_DEPTH  : number of entries in the output buffer
package fifo_burst_reader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned SKID_DEPTH = 2;

endpackage

// File: rtl/fifo_burst_reader_skid_buf.sv
// Two-entry in-order buffer between the FIFO read port and the output stream.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset (drops buffered words)
//   push_i/din_i : write din_i at the tail
//   pop_i        : remove the head word
//   occ_o        : occupancy 0..2
//   valid_o      : registered "occupancy non-zero"
//   head_o       : registered head word
module fifo_skid_buf
    import fifo_burst_reader_pkg::*;
#(
    parameter int unsigned DATA_WD = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               push_i,
    input  logic [DATA_WD-1:0] din_i,
    input  logic               pop_i,
    output logic [1:0]         occ_o,
    output logic               valid_o,
    output logic [DATA_WD-1:0] head_o
);

    logic [DATA_WD-1:0] head_q, head_d;
    logic [DATA_WD-1:0] tail_q, tail_d;
    logic [1:0]         occ_q, occ_d;
    logic               valid_q;
    logic               pop_ok, push_ok;

    // A push into a full buffer is only accepted when the head leaves on the same edge.
    assign pop_ok  = pop_i && (occ_q != 2'd0);
    assign push_ok = push_i && ((occ_q != 2'(SKID_DEPTH)) || pop_ok);

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        case (occ_q)
            2'd0: begin
                if (push_ok) begin
                    head_d = din_i;
                    occ_d  = 2'd1;
                end
            end
            2'd1: begin
                case ({push_ok, pop_ok})
                    2'b10: begin
                        tail_d = din_i;
                        occ_d  = 2'd2;
                    end
                    2'b01: occ_d = 2'd0;
                    2'b11: head_d = din_i;
                    default: ;
                endcase
            end
            2'd2: begin
                if (pop_ok) begin
                    head_d = tail_q;
                    if (push_ok) begin
                        tail_d = din_i;
                    end else begin
                        occ_d = 2'd1;
                    end
                end
            end
            default: occ_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            occ_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            occ_q   <= occ_d;
            valid_q <= (occ_d != 2'd0);
        end
    end

    assign occ_o   = occ_q;
    assign valid_o = valid_q;
    assign head_o  = head_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Burst reader: pulls a requested number of words from a FIFO read port and
// streams them out over a valid/ready interface through a 2-entry buffer.
// Ports:
//   rclk, rrst      : clock, synchronous active-high reset
//   start, len      : burst request and word count (sampled in IDLE only)
//   busy, done      : RUN-state flag, one-cycle completion pulse
//   rempty, rinc,
//   rdata           : FIFO read port (rinc pops rdata on the same edge)
//   m_valid, m_data,
//   m_ready         : output stream
//   words_out       : words accepted downstream in the current/last burst
module fifo_burst_reader
    import fifo_burst_reader_pkg::*;
#(
    parameter int unsigned DATA_WD = 8,
    parameter int unsigned LEN_WD  = 8
) (
    input  logic               rclk,
    input  logic               rrst,
    input  logic               start,
    input  logic [LEN_WD-1:0]  len,
    output logic               busy,
    output logic               done,
    input  logic               rempty,
    output logic               rinc,
    input  logic [DATA_WD-1:0] rdata,
    output logic               m_valid,
    output logic [DATA_WD-1:0] m_data,
    input  logic               m_ready,
    output logic [LEN_WD-1:0]  words_out
);

    state_e             state_q, state_d;
    logic [LEN_WD-1:0]  remaining_q, remaining_d;
    logic [LEN_WD-1:0]  words_out_q, words_out_d;
    logic [1:0]         occ;
    logic               rinc_w;
    logic               pop_w;

    // Fill decision uses only registered state and the FIFO flag, never m_ready.
    assign rinc_w = (state_q == RUN) && !rempty && (remaining_q != '0) && (occ != 2'(SKID_DEPTH));
    assign pop_w  = m_valid && m_ready;

    fifo_skid_buf #(
        .DATA_WD(DATA_WD)
    ) u_buf (
        .clk_i  (rclk),
        .rst_i  (rrst),
        .push_i (rinc_w),
        .din_i  (rdata),
        .pop_i  (pop_w),
        .occ_o  (occ),
        .valid_o(m_valid),
        .head_o (m_data)
    );

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        words_out_d = words_out_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    words_out_d = '0;
                    if (len != '0) begin
                        remaining_d = len;
                        state_d     = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                if (rinc_w) begin
                    remaining_d = remaining_q - LEN_WD'(1);
                end
                if (pop_w && (words_out_q != '1)) begin
                    words_out_d = words_out_q + LEN_WD'(1);
                end
                // Finish once nothing is left to fetch and the buffer empties on this edge.
                if ((remaining_q == '0) && ((occ == 2'd0) || ((occ == 2'd1) && pop_w))) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            words_out_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            words_out_q <= words_out_d;
        end
    end

    assign rinc      = rinc_w;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign words_out = words_out_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
module tb_fifo_burst_reader;

    logic       rclk = 1'b0;
    logic       rrst;
    logic       start;
    logic [7:0] len;
    logic       busy, done;
    logic       rempty, rinc;
    logic [7:0] rdata;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready;
    logic [7:0] words_out;

    always #5 rclk = ~rclk;

    fifo_burst_reader #(
        .DATA_WD(8),
        .LEN_WD (8)
    ) dut (
        .rclk     (rclk),
        .rrst     (rrst),
        .start    (start),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .rempty   (rempty),
        .rinc     (rinc),
        .rdata    (rdata),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_ready  (m_ready),
        .words_out(words_out)
    );

    // Source FIFO model: array plus read/write counters.
    logic [7:0]  fmem [0:255];
    int unsigned wr_cnt = 0;
    int unsigned rd_cnt = 0;
    assign rempty = (wr_cnt == rd_cnt);
    assign rdata  = fmem[rd_cnt[7:0]];

    always @(posedge rclk) begin
        if (rinc && !rempty) rd_cnt <= rd_cnt + 1;
    end

    // Observation: transfers, pops and done pulses due at the next rising edge.
    logic [7:0]  got_q [$];
    int unsigned rinc_cnt = 0;
    int unsigned done_cnt = 0;
    int unsigned rinc_empty_cnt = 0;

    always @(negedge rclk) begin
        if (rinc) rinc_cnt <= rinc_cnt + 1;
        if (rinc && rempty) rinc_empty_cnt <= rinc_empty_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (m_valid && m_ready && !rrst) got_q.push_back(m_data);
    end

    int errors = 0;
    int checks = 0;

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] d);
        fmem[wr_cnt[7:0]] = d;
        wr_cnt = wr_cnt + 1;
    endtask

    task automatic test_reset();
        rrst = 1'b1; start = 1'b1; len = 8'd3; m_ready = 1'b0;
        tick();
        tick();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (words_out !== 8'd0) begin errors++; $display("FAIL reset_words_out: got %0d expected 0", words_out); end
        checks++; if (rinc !== 1'b0) begin errors++; $display("FAIL reset_rinc: got %b expected 0", rinc); end
        start = 1'b0; len = 8'd0;
        rrst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int unsigned rb, db, gb;
        for (int i = 0; i < 5; i++) push_word(8'(8'h10 + i));
        rb = rinc_cnt; db = done_cnt; gb = got_q.size();
        m_ready = 1'b1;
        start = 1'b1; len = 8'd5;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (m_valid !== 1'b1 || m_data !== 8'(8'h10 + i)) begin
                errors++;
                $display("FAIL basic_stream[%0d]: got valid=%b data=%h expected valid=1 data=%h", i, m_valid, m_data, 8'(8'h10 + i));
            end
        end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done: got %b expected 1", done); end
        checks++; if (words_out !== 8'd5) begin errors++; $display("FAIL basic_words_out: got %0d expected 5", words_out); end
        tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_idle: got done=%b busy=%b expected 0 0", done, busy); end
        checks++; if (rinc_cnt - rb != 5) begin errors++; $display("FAIL basic_rinc_count: got %0d expected 5", rinc_cnt - rb); end
        checks++; if (done_cnt - db != 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt - db); end
        checks++; if (got_q.size() - gb != 5) begin errors++; $display("FAIL basic_xfer_count: got %0d expected 5", got_q.size() - gb); end
    endtask

    task automatic test_zero_len();
        int unsigned rb, db;
        rb = rinc_cnt; db = done_cnt;
        start = 1'b1; len = 8'd0;
        tick();
        start = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b expected 1", done); end
        checks++; if (words_out !== 8'd0) begin errors++; $display("FAIL zero_words_out: got %0d expected 0", words_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b expected 0", busy); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_width: got %b expected 0", done); end
        tick();
        tick();
        checks++; if (done_cnt - db != 1) begin errors++; $display("FAIL zero_done_count: got %0d expected 1", done_cnt - db); end
        checks++; if (rinc_cnt != rb) begin errors++; $display("FAIL zero_rinc: got %0d pops expected 0", rinc_cnt - rb); end
    endtask

    task automatic test_backpressure();
        int unsigned rb, gb, rd0, c;
        logic [7:0] w0, exp_w;
        rd0 = rd_cnt;
        for (int i = 0; i < 4; i++) push_word(8'($urandom));
        w0 = fmem[rd0[7:0]];
        rb = rinc_cnt; gb = got_q.size();
        m_ready = 1'b0;
        start = 1'b1; len = 8'd4;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (m_valid !== 1'b1 || m_data !== w0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got valid=%b data=%h expected valid=1 data=%h", i, m_valid, m_data, w0);
            end
        end
        checks++; if (rinc_cnt - rb != 2) begin errors++; $display("FAIL bp_rinc_stalled: got %0d expected 2", rinc_cnt - rb); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy: got %b expected 1", busy); end
        m_ready = 1'b1;
        c = 0;
        while (done !== 1'b1 && c < 20) begin tick(); c++; end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_done_timeout: got %b expected 1", done); end
        checks++; if (words_out !== 8'd4) begin errors++; $display("FAIL bp_words_out: got %0d expected 4", words_out); end
        checks++;
        if (got_q.size() - gb != 4) begin
            errors++; $display("FAIL bp_xfer_count: got %0d expected 4", got_q.size() - gb);
        end else begin
            for (int i = 0; i < 4; i++) begin
                exp_w = fmem[8'(rd0 + i)];
                checks++;
                if (got_q[gb + i] !== exp_w) begin errors++; $display("FAIL bp_order[%0d]: got %h expected %h", i, got_q[gb + i], exp_w); end
            end
        end
        tick();
    endtask

    task automatic test_underflow();
        int unsigned rb, gb, rd0, c;
        logic [7:0] exp_w;
        rd0 = rd_cnt;
        push_word(8'($urandom)); push_word(8'($urandom));
        rb = rinc_cnt; gb = got_q.size();
        m_ready = 1'b1;
        start = 1'b1; len = 8'd4;
        tick();
        start = 1'b0;
        repeat (5) tick();
        checks++; if (rinc_cnt - rb != 2) begin errors++; $display("FAIL uf_rinc_stalled: got %0d expected 2", rinc_cnt - rb); end
        checks++; if (busy !== 1'b1 || m_valid !== 1'b0) begin errors++; $display("FAIL uf_drained: got busy=%b valid=%b expected 1 0", busy, m_valid); end
        push_word(8'($urandom)); push_word(8'($urandom));
        c = 0;
        while (done !== 1'b1 && c < 20) begin tick(); c++; end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL uf_done_timeout: got %b expected 1", done); end
        checks++; if (words_out !== 8'd4) begin errors++; $display("FAIL uf_words_out: got %0d expected 4", words_out); end
        checks++;
        if (got_q.size() - gb != 4) begin
            errors++; $display("FAIL uf_xfer_count: got %0d expected 4", got_q.size() - gb);
        end else begin
            for (int i = 0; i < 4; i++) begin
                exp_w = fmem[8'(rd0 + i)];
                checks++;
                if (got_q[gb + i] !== exp_w) begin errors++; $display("FAIL uf_order[%0d]: got %h expected %h", i, got_q[gb + i], exp_w); end
            end
        end
        tick();
    endtask

    task automatic test_start_ignored();
        int unsigned rb, db, gb, rd0, c;
        logic [7:0] exp_w;
        rd0 = rd_cnt;
        for (int i = 0; i < 9; i++) push_word(8'($urandom));
        rb = rinc_cnt; db = done_cnt; gb = got_q.size();
        m_ready = 1'b1;
        start = 1'b1; len = 8'd9;
        tick();
        start = 1'b0;
        repeat (3) tick();
        start = 1'b1; len = 8'd2;
        tick();
        start = 1'b0; len = 8'd0;
        c = 0;
        while (done !== 1'b1 && c < 30) begin tick(); c++; end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL ign_done_timeout: got %b expected 1", done); end
        checks++; if (words_out !== 8'd9) begin errors++; $display("FAIL ign_words_out: got %0d expected 9", words_out); end
        tick();
        tick();
        checks++; if (rinc_cnt - rb != 9) begin errors++; $display("FAIL ign_rinc_count: got %0d expected 9", rinc_cnt - rb); end
        checks++; if (done_cnt - db != 1) begin errors++; $display("FAIL ign_done_count: got %0d expected 1", done_cnt - db); end
        checks++;
        if (got_q.size() - gb != 9) begin
            errors++; $display("FAIL ign_xfer_count: got %0d expected 9", got_q.size() - gb);
        end else begin
            for (int i = 0; i < 9; i++) begin
                exp_w = fmem[8'(rd0 + i)];
                checks++;
                if (got_q[gb + i] !== exp_w) begin errors++; $display("FAIL ign_order[%0d]: got %h expected %h", i, got_q[gb + i], exp_w); end
            end
        end
    endtask

    task automatic test_random();
        int unsigned n, pushed, rb, gb, rd0, c;
        logic        stall_prev;
        logic [7:0]  stall_data, exp_w;
        for (int iter = 0; iter < 8; iter++) begin
            n = $urandom_range(1, 12);
            rd0 = rd_cnt;
            pushed = $urandom_range(0, n);
            for (int i = 0; i < int'(pushed); i++) push_word(8'($urandom));
            rb = rinc_cnt; gb = got_q.size();
            m_ready = 1'($urandom);
            start = 1'b1; len = 8'(n);
            stall_prev = 1'b0; stall_data = '0;
            tick();
            start = 1'b0;
            c = 0;
            while (done !== 1'b1 && c < 300) begin
                m_ready = ($urandom_range(0, 3) != 0);
                if (pushed < n && $urandom_range(0, 2) == 0) begin
                    push_word(8'($urandom));
                    pushed++;
                end
                stall_prev = m_valid && !m_ready;
                stall_data = m_data;
                tick();
                c++;
                if (stall_prev) begin
                    checks++;
                    if (m_valid !== 1'b1 || m_data !== stall_data) begin
                        errors++;
                        $display("FAIL rnd_hold[%0d]: got valid=%b data=%h expected valid=1 data=%h", iter, m_valid, m_data, stall_data);
                    end
                end
            end
            checks++; if (done !== 1'b1) begin errors++; $display("FAIL rnd_done_timeout[%0d]: got %b expected 1", iter, done); end
            checks++; if (words_out !== 8'(n)) begin errors++; $display("FAIL rnd_words_out[%0d]: got %0d expected %0d", iter, words_out, n); end
            checks++; if (rinc_cnt - rb != n) begin errors++; $display("FAIL rnd_rinc_count[%0d]: got %0d expected %0d", iter, rinc_cnt - rb, n); end
            checks++;
            if (got_q.size() - gb != n) begin
                errors++; $display("FAIL rnd_xfer_count[%0d]: got %0d expected %0d", iter, got_q.size() - gb, n);
            end else begin
                for (int i = 0; i < int'(n); i++) begin
                    exp_w = fmem[8'(rd0 + i)];
                    checks++;
                    if (got_q[gb + i] !== exp_w) begin errors++; $display("FAIL rnd_order[%0d.%0d]: got %h expected %h", iter, i, got_q[gb + i], exp_w); end
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        int unsigned gb, rd0, rd1, c;
        logic [7:0] exp_w;
        rd0 = rd_cnt;
        for (int i = 0; i < 10; i++) push_word(8'($urandom));
        gb = got_q.size();
        m_ready = 1'b1;
        start = 1'b1; len = 8'd8;
        tick();
        start = 1'b0;
        c = 0;
        while (got_q.size() - gb < 3 && c < 20) begin tick(); c++; end
        checks++; if (got_q.size() - gb != 3) begin errors++; $display("FAIL rst_pre_xfers: got %0d expected 3", got_q.size() - gb); end
        rrst = 1'b1;
        tick();
        rrst = 1'b0;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", m_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        checks++; if (words_out !== 8'd0) begin errors++; $display("FAIL rst_mid_words_out: got %0d expected 0", words_out); end
        rd1 = rd_cnt;
        gb = got_q.size();
        start = 1'b1; len = 8'd2;
        tick();
        start = 1'b0;
        c = 0;
        while (done !== 1'b1 && c < 20) begin tick(); c++; end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL rst_new_done_timeout: got %b expected 1", done); end
        checks++; if (words_out !== 8'd2) begin errors++; $display("FAIL rst_new_words_out: got %0d expected 2", words_out); end
        checks++;
        if (got_q.size() - gb != 2) begin
            errors++; $display("FAIL rst_new_xfer_count: got %0d expected 2", got_q.size() - gb);
        end else begin
            for (int i = 0; i < 2; i++) begin
                exp_w = fmem[8'(rd1 + i)];
                checks++;
                if (got_q[gb + i] !== exp_w) begin errors++; $display("FAIL rst_new_order[%0d]: got %h expected %h", i, got_q[gb + i], exp_w); end
            end
        end
        checks++; if (rd1 - rd0 < 3) begin errors++; $display("FAIL rst_fifo_pops: got %0d expected at least 3", rd1 - rd0); end
        tick();
    endtask

    initial begin
        rrst = 1'b1; start = 1'b0; len = '0; m_ready = 1'b0;
        test_reset();
        test_basic();
        test_zero_len();
        test_backpressure();
        test_underflow();
        test_start_ignored();
        test_random();
        test_reset_mid();
        checks++;
        if (rinc_empty_cnt != 0) begin errors++; $display("FAIL rinc_while_empty: got %0d expected 0", rinc_empty_cnt); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
